// File: rtl/id_bpred.sv
// Decode-stage dynamic branch predictor: PC-indexed 2-bit counters, trained from EX.
// Optional return-address stack for jalr returns is compiled in with `define BPRED_RAS_EN.
module id_bpred #(
  parameter int         IDX_BITS  = 6,
  parameter logic [1:0] INIT_CTR  = 2'b01,
  parameter int         RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic        ex_flush,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_inst,
  input  logic [31:0] id_imm,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  output logic        id_pred_taken,
  output logic [31:0] id_pred_target,
  output logic        ex_pred_taken,
  output logic        busy
);

  localparam int ENTRIES = 1 << IDX_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              state, state_nxt;
  logic [IDX_BITS-1:0] sweep_ptr;
  logic                sweep_we;
  logic                run;
  logic [1:0]          ctr_tbl [ENTRIES];

  logic [IDX_BITS-1:0] upd_idx, id_idx;
  logic                upd_en;
  logic [1:0]          upd_old, upd_new, id_ctr;
  logic [6:0]          opcode;
  logic                is_br, is_jal;
  logic                ras_hit;
  logic [31:0]         ras_target;
  logic                unused_bits;

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("id_bpred: RAS_DEPTH must be a power of 2 and at least 2");
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && sweep_ptr == {IDX_BITS{1'b1}}) state_nxt = ST_RUN;
  end

  always_comb begin
    busy     = (state == ST_INIT);
    sweep_we = (state == ST_INIT) & ~rst;
    run      = (state == ST_RUN) & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst)           sweep_ptr <= '0;
    else if (sweep_we) sweep_ptr <= sweep_ptr + IDX_BITS'(1);
  end

  // Training only happens once the sweep is done; the sweep owns the write port while busy.
  assign upd_en  = run & upd_valid;
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_old = ctr_tbl[upd_idx];

  always_comb begin
    upd_new = upd_old;
    if (upd_taken) begin
      if (upd_old != 2'd3) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != 2'd0) upd_new = upd_old - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_we)    ctr_tbl[sweep_ptr] <= INIT_CTR;
    else if (upd_en) ctr_tbl[upd_idx]   <= upd_new;
  end

  // Write-first bypass so a same-cycle update of the ID index is seen by the prediction.
  assign id_idx = id_pc[IDX_BITS+1:2];
  assign id_ctr = (upd_en && upd_idx == id_idx) ? upd_new : ctr_tbl[id_idx];

  assign opcode = id_inst[6:0];
  assign is_br  = (opcode == 7'b1100011);
  assign is_jal = (opcode == 7'b1101111);

  assign id_pred_taken  = (run & id_valid & ((is_br & id_ctr[1]) | is_jal)) | ras_hit;
  assign id_pred_target = ras_hit ? ras_target : (id_pc + id_imm);

  always_ff @(posedge clk) begin
    if (rst | ex_flush) ex_pred_taken <= 1'b0;
    else if (~id_stall) ex_pred_taken <= id_pred_taken;
  end

`ifdef BPRED_RAS_EN
  localparam int RP = $clog2(RAS_DEPTH);

  logic [31:0] ras_mem [RAS_DEPTH];
  logic [RP-1:0] ras_tos, ras_tos_nxt, ras_wr_ptr;
  logic [RP:0]   ras_cnt, ras_cnt_nxt;
  logic [4:0]    rd, rs1;
  logic          rd_link, rs1_link, is_jalr, is_ret, fire;
  logic          ras_push, ras_pop_ok, ras_wr_en;

  assign rd       = id_inst[11:7];
  assign rs1      = id_inst[19:15];
  assign rd_link  = (rd == 5'd1) || (rd == 5'd5);
  assign rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
  assign is_jalr  = (opcode == 7'b1100111);
  assign is_ret   = is_jalr & rs1_link & (~rd_link | (rd != rs1));
  assign fire     = id_valid & ~id_stall & ~ex_flush;

  assign ras_push   = run & fire & (is_jal | is_jalr) & rd_link;
  assign ras_pop_ok = run & fire & is_ret & (ras_cnt != '0);
  assign ras_hit    = run & id_valid & is_ret & (ras_cnt != '0);
  assign ras_target = {ras_mem[ras_tos][31:1], 1'b0};

  // A pop followed by a push lands in the slot just vacated, so the pointer stays put.
  always_comb begin
    ras_tos_nxt = ras_tos;
    ras_cnt_nxt = ras_cnt;
    ras_wr_en   = 1'b0;
    ras_wr_ptr  = ras_tos;
    if (ras_push && ras_pop_ok) begin
      ras_wr_en = 1'b1;
    end else if (ras_push) begin
      ras_tos_nxt = ras_tos + RP'(1);
      ras_wr_ptr  = ras_tos + RP'(1);
      ras_wr_en   = 1'b1;
      if (ras_cnt != (RP+1)'(RAS_DEPTH)) ras_cnt_nxt = ras_cnt + (RP+1)'(1);
    end else if (ras_pop_ok) begin
      ras_tos_nxt = ras_tos - RP'(1);
      ras_cnt_nxt = ras_cnt - (RP+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ras_tos <= '0;
      ras_cnt <= '0;
    end else begin
      ras_tos <= ras_tos_nxt;
      ras_cnt <= ras_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_wr_en) ras_mem[ras_wr_ptr] <= id_pc + 32'd4;
  end
`else
  assign ras_hit    = 1'b0;
  assign ras_target = 32'd0;
`endif

  assign unused_bits = ^{id_inst, id_pc, upd_pc};

endmodule

// File: tb/tb_id_bpred.sv
// Directed, table-driven bench for id_bpred: reset sweep, training, bypass, ID/EX register,
// jal/non-branch handling, plus return-address stack sequences when BPRED_RAS_EN is defined.
module tb_id_bpred;

  localparam logic [31:0] BEQ      = 32'h0000_0063;
  localparam logic [31:0] JAL0     = 32'h0000_006F;
  localparam logic [31:0] JAL1     = 32'h0000_00EF;
  localparam logic [31:0] ADD      = 32'h0000_0033;
  localparam logic [31:0] JALR_RET = 32'h0000_8067;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0, id_stall = 1'b0, ex_flush = 1'b0;
  logic [31:0] id_pc = '0, id_inst = '0, id_imm = '0;
  logic        upd_valid = 1'b0, upd_taken = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        id_pred_taken, ex_pred_taken, busy;
  logic [31:0] id_pred_target;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        valid, stall, flush;
    logic [31:0] pc, inst, imm;
    logic        upd_v;
    logic [31:0] upd_pc;
    logic        upd_t;
    logic        exp_taken;
    logic [31:0] exp_tgt;
    logic        exp_ex;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  id_bpred #(.IDX_BITS(6), .INIT_CTR(2'b01), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_stall(id_stall), .ex_flush(ex_flush),
    .id_pc(id_pc), .id_inst(id_inst), .id_imm(id_imm),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .ex_pred_taken(ex_pred_taken), .busy(busy)
  );

  function automatic vec_t mk(input logic v, input logic st, input logic fl,
                              input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] imm,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic et, input logic [31:0] etgt, input logic eex);
    vec_t r;
    r.valid = v; r.stall = st; r.flush = fl;
    r.pc = pc; r.inst = inst; r.imm = imm;
    r.upd_v = uv; r.upd_pc = upc; r.upd_t = ut;
    r.exp_taken = et; r.exp_tgt = etgt; r.exp_ex = eex;
    return r;
  endfunction

  function automatic vec_t upd(input logic [31:0] upc, input logic ut);
    return mk(1'b0, 1'b0, 1'b0, 32'h0, ADD, 32'h0, 1'b1, upc, ut, 1'b0, 32'h0, 1'b0);
  endfunction

  function automatic vec_t br(input logic [31:0] pc, input logic [31:0] imm, input logic et);
    return mk(1'b1, 1'b0, 1'b0, pc, BEQ, imm, 1'b0, 32'h0, 1'b0, et, pc + imm, et);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    id_valid  = v.valid;  id_stall = v.stall; ex_flush = v.flush;
    id_pc     = v.pc;     id_inst  = v.inst;  id_imm   = v.imm;
    upd_valid = v.upd_v;  upd_pc   = v.upd_pc; upd_taken = v.upd_t;
  endtask

  task automatic runVec(input string tag, input vec_t v);
    applyStimulus(v);
    #1;
    checkOutput({tag, ".taken"},  {31'b0, id_pred_taken}, {31'b0, v.exp_taken});
    checkOutput({tag, ".target"}, id_pred_target, v.exp_tgt);
    checkOutput({tag, ".busy"},   {31'b0, busy}, 32'd0);
    tick();
    checkOutput({tag, ".ex"},     {31'b0, ex_pred_taken}, {31'b0, v.exp_ex});
  endtask

  // Count cycles with busy high, checking that predictions stay off throughout.
  task automatic countBusy(input logic inject, output int n);
    n = 0;
    while (busy && n < 200) begin
      upd_valid = inject && (n == 40 || n == 41);
      upd_pc    = 32'h1000;
      upd_taken = 1'b1;
      #1;
      checkOutput($sformatf("sweep%0d.taken", n), {31'b0, id_pred_taken}, 32'd0);
      tick();
      n++;
    end
    upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;

    // Reset with a jal in ID: no prediction may escape during reset or the sweep.
    id_valid = 1'b1; id_pc = 32'h2000; id_inst = JAL0; id_imm = 32'h100;
    rst = 1'b1;
    tick(); tick();
    checkOutput("rst.busy",  {31'b0, busy}, 32'd1);
    checkOutput("rst.taken", {31'b0, id_pred_taken}, 32'd0);
    checkOutput("rst.ex",    {31'b0, ex_pred_taken}, 32'd0);
    rst = 1'b0;
    countBusy(1'b0, n);
    checkOutput("sweep.len", n, 32'd64);

    // Restart mid-sweep; the late updates must be ignored while still busy.
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (30) tick();
    checkOutput("restart.busy30", {31'b0, busy}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    countBusy(1'b1, n);
    checkOutput("restart.len", n, 32'd64);

    // Counter for index 0 (0x1000, 0x1100, 0x2000 alias) starts at 1; ex_pred_taken at 0.
    vecs.push_back(br(32'h1000, 32'h20, 1'b0));
    vecs.push_back(upd(32'h1000, 1'b1));
    vecs.push_back(upd(32'h1000, 1'b1));
    vecs.push_back(br(32'h1000, 32'h20, 1'b1));
    vecs.push_back(upd(32'h1000, 1'b0));
    vecs.push_back(upd(32'h1000, 1'b0));
    vecs.push_back(br(32'h1000, 32'h20, 1'b0));
    for (int i = 0; i < 4; i++) vecs.push_back(upd(32'h1000, 1'b1));
    vecs.push_back(upd(32'h1000, 1'b0));
    vecs.push_back(br(32'h1000, 32'h20, 1'b1));
    for (int i = 0; i < 4; i++) vecs.push_back(upd(32'h1000, 1'b0));
    vecs.push_back(upd(32'h1000, 1'b1));
    vecs.push_back(br(32'h1000, 32'h20, 1'b0));
    vecs.push_back(mk(1, 0, 0, 32'h1000, BEQ, 32'h20, 1, 32'h1000, 1, 1, 32'h1020, 1));
    vecs.push_back(mk(1, 0, 0, 32'h1104, BEQ, 32'h20, 1, 32'h1000, 1, 0, 32'h1124, 0));
    vecs.push_back(upd(32'h1003, 1'b0));
    vecs.push_back(br(32'h1000, 32'h20, 1'b1));
    vecs.push_back(br(32'h1100, 32'h20, 1'b1));
    // ID/EX register: stall holds, flush clears, stall-release loads.
    vecs.push_back(mk(1, 0, 0, 32'h1000, ADD, 32'h20, 0, 0, 0, 0, 32'h1020, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 1, 0, 32'h1000, BEQ, 32'h20, 0, 0, 0, 1, 32'h1020, 0));
    vecs.push_back(br(32'h1000, 32'h20, 1'b1));
    vecs.push_back(mk(1, 1, 0, 32'h1000, ADD, 32'h20, 0, 0, 0, 0, 32'h1020, 1));
    vecs.push_back(mk(1, 1, 1, 32'h1000, BEQ, 32'h20, 0, 0, 0, 1, 32'h1020, 0));
    vecs.push_back(br(32'h1000, 32'h20, 1'b1));
    vecs.push_back(mk(1, 0, 1, 32'h1000, BEQ, 32'h20, 0, 0, 0, 1, 32'h1020, 0));
    // jal ignores the counter; other instructions and bubbles never predict.
    for (int i = 0; i < 3; i++) vecs.push_back(upd(32'h2000, 1'b0));
    vecs.push_back(br(32'h2000, 32'h100, 1'b0));
    vecs.push_back(mk(1, 0, 0, 32'h2000, JAL0, 32'h100, 0, 0, 0, 1, 32'h2100, 1));
    vecs.push_back(mk(1, 0, 0, 32'h2000, ADD, 32'h100, 0, 0, 0, 0, 32'h2100, 0));
    vecs.push_back(mk(0, 0, 0, 32'h2000, JAL0, 32'h100, 0, 0, 0, 0, 32'h2100, 0));
    vecs.push_back(mk(1, 0, 0, 32'h2000, JALR_RET, 32'h100, 0, 0, 0, 0, 32'h2100, 0));

    foreach (vecs[i]) runVec($sformatf("vec%0d", i), vecs[i]);

`ifdef BPRED_RAS_EN
    runVec("ras.call", mk(1, 0, 0, 32'h3000, JAL1, 32'h100, 0, 0, 0, 1, 32'h3100, 1));
    runVec("ras.ret",  mk(1, 0, 0, 32'h3100, JALR_RET, 32'h0, 0, 0, 0, 1, 32'h3004, 1));
    runVec("ras.empty", mk(1, 0, 0, 32'h3100, JALR_RET, 32'h0, 0, 0, 0, 0, 32'h3100, 0));
    for (int k = 0; k < 5; k++)
      runVec($sformatf("ras.push%0d", k),
             mk(1, 0, 0, 32'h4000 + 32'(16 * k), JAL1, 32'h40, 0, 0, 0, 1, 32'h4040 + 32'(16 * k), 1));
    for (int k = 0; k < 4; k++)
      runVec($sformatf("ras.pop%0d", k),
             mk(1, 0, 0, 32'h5000, JALR_RET, 32'h0, 0, 0, 0, 1, 32'h4044 - 32'(16 * k), 1));
    runVec("ras.pop4", mk(1, 0, 0, 32'h5000, JALR_RET, 32'h0, 0, 0, 0, 0, 32'h5000, 0));
`endif

    // Reset taken from RUN: the prediction is suppressed in the reset cycle itself.
    applyStimulus(mk(1, 0, 0, 32'h2000, JAL0, 32'h100, 0, 0, 0, 0, 32'h2100, 0));
    tick();
    checkOutput("rerun.ex", {31'b0, ex_pred_taken}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rerun.rst_taken", {31'b0, id_pred_taken}, 32'd0);
    tick();
    checkOutput("rerun.busy", {31'b0, busy}, 32'd1);
    checkOutput("rerun.ex0",  {31'b0, ex_pred_taken}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
